// File: rtl/mux_sched.sv
// Round-robin scheduler driving the enables of a shared 4:1 priority mux.
// One requester owns the output line at a time; each grant is capped at
// MAX_HOLD cycles and is always followed by at least one idle cycle.
module mux_sched #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] owner,
  output logic       busy,
  output logic       en1,
  output logic       en2,
  output logic       en3
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Last count value of a grant; MAX_HOLD-1 always fits in CNT_W bits.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_next;
  logic [1:0]       ptr, ptr_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       owner_next;
  logic [3:0]       grant_next;
  logic             busy_next;
  logic [2:0]       en_next;      // {en3, en2, en1}
  logic [2:0]       en_q;

  logic [1:0]       winner;
  logic             any_req;
  logic             release_now;

  // Mux enable pattern {en3, en2, en1} that steers the mux to a given input.
  function automatic logic [2:0] enc_for(input logic [1:0] idx);
    logic [2:0] e;
    case (idx)
      2'd0:    e = 3'b110;
      2'd1:    e = 3'b111;
      2'd2:    e = 3'b100;
      default: e = 3'b000;
    endcase
    return e;
  endfunction

  // Rotating search starting just after the last winner; the last winner
  // itself is examined last, so it is lowest priority.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] w;
    logic       found;
    logic [1:0] idx;
    w     = p;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = p + 2'(i);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  // Arbitration and release decision from current state and inputs.
  always_comb begin
    any_req     = |req;
    winner      = pick(req, ptr);
    release_now = !req[owner] || (cnt == HOLD_LAST);
  end

  // Next-state and next-output logic for the grant FSM.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    state_next = state;
    ptr_next   = ptr;
    cnt_next   = cnt;
    owner_next = owner;
    grant_next = grant;
    busy_next  = busy;
    en_next    = en_q;

    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = GRANT;
          ptr_next   = winner;
          owner_next = winner;
          cnt_next   = '0;
          grant_next = 4'b0001 << winner;
          busy_next  = 1'b1;
          en_next    = enc_for(winner);
        end
      end
      GRANT: begin
        if (release_now) begin
          // Owner and pointer are kept so the rotation resumes after them.
          state_next = IDLE;
          cnt_next   = '0;
          grant_next = 4'b0000;
          busy_next  = 1'b0;
          en_next    = 3'b000;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = 4'b0000;
        busy_next  = 1'b0;
        en_next    = 3'b000;
      end
    endcase
  end

  // State and output registers; reset clears outputs without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd3;
      cnt   <= '0;
      owner <= 2'd0;
      grant <= 4'b0000;
      busy  <= 1'b0;
      en_q  <= 3'b000;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      cnt   <= cnt_next;
      owner <= owner_next;
      grant <= grant_next;
      busy  <= busy_next;
      en_q  <= en_next;
    end
  end

  assign en3 = en_q[2];
  assign en2 = en_q[1];
  assign en1 = en_q[0];

endmodule

// File: tb/tb_mux_sched.sv
// Directed bench for mux_sched: one DUT with MAX_HOLD=4, one with MAX_HOLD=1.
module tb_mux_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       busy, en1, en2, en3;

  logic       rst1;
  logic [3:0] req1;
  logic [3:0] grant1;
  logic [1:0] owner1;
  logic       busy1, en1_1, en2_1, en3_1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_sched #(.MAX_HOLD(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .owner(owner),
    .busy(busy), .en1(en1), .en2(en2), .en3(en3)
  );

  mux_sched #(.MAX_HOLD(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst1), .req(req1), .grant(grant1), .owner(owner1),
    .busy(busy1), .en1(en1_1), .en2(en2_1), .en3(en3_1)
  );

  // Expected {en3,en2,en1} for each owner, from the mux enable table.
  function automatic logic [2:0] exp_en(input int idx);
    case (idx)
      0:       return 3'b110;
      1:       return 3'b111;
      2:       return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_main(input logic [3:0] r);
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
    req = r;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b0000;
    rst1 = 1'b1;
    req1 = 4'b0000;
    #1;
    checks++;
    if ({grant, owner, busy, en3, en2, en1} !== 10'b0) begin
      errors++;
      $display("FAIL reset_init got g=%b o=%0d b=%b en=%b%b%b want all 0",
               grant, owner, busy, en3, en2, en1);
    end
    tick();
    rst = 1'b0;
    rst1 = 1'b0;
    // Grant b so ptr moves to 1, then reset mid-grant.
    req = 4'b0010;
    tick();
    checks++;
    if (grant !== 4'b0010 || {en3, en2, en1} !== 3'b111 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_pregrant got g=%b en=%b%b%b b=%b want 0010 111 1",
               grant, en3, en2, en1, busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({grant, busy, en3, en2, en1} !== 8'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL reset_async got g=%b o=%0d b=%b en=%b%b%b want 0000 0 0 000",
               grant, owner, busy, en3, en2, en1);
    end
    tick();
    rst = 1'b0;
    // ptr back at 3: a wins among all four.
    req = 4'b1111;
    tick();
    checks++;
    if (grant !== 4'b0001 || owner !== 2'd0 || {en3, en2, en1} !== 3'b110) begin
      errors++;
      $display("FAIL reset_ptr got g=%b o=%0d en=%b%b%b want 0001 0 110",
               grant, owner, en3, en2, en1);
    end
  endtask

  task automatic test_single_hold();
    logic [3:0] eg;
    reset_main(4'b0100);
    for (int i = 0; i < 11; i++) begin
      tick();
      eg = (i % 5 == 4) ? 4'b0000 : 4'b0100;
      checks++;
      if (grant !== eg || busy !== (eg != 0) ||
          {en3, en2, en1} !== ((eg != 0) ? 3'b100 : 3'b000)) begin
        errors++;
        $display("FAIL single_hold cyc%0d got g=%b b=%b en=%b%b%b want g=%b",
                 i, grant, busy, en3, en2, en1, eg);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    logic [2:0] ee;
    int         slot;
    reset_main(4'b1111);
    for (int i = 0; i < 25; i++) begin
      tick();
      slot = (i / 5) % 4;
      if (i % 5 == 4) begin
        eg = 4'b0000;
        ee = 3'b000;
      end else begin
        eg = 4'b0001 << slot;
        ee = exp_en(slot);
      end
      checks++;
      if (grant !== eg || {en3, en2, en1} !== ee || busy !== (eg != 0) ||
          ((eg != 0) && owner !== 2'(slot))) begin
        errors++;
        $display("FAIL round_robin cyc%0d got g=%b o=%0d en=%b%b%b b=%b want g=%b en=%b",
                 i, grant, owner, en3, en2, en1, busy, eg, ee);
      end
    end
  endtask

  task automatic test_early_release();
    reset_main(4'b0010);
    tick();
    checks++;
    if (grant !== 4'b0010 || busy !== 1'b1) begin
      errors++;
      $display("FAIL early_c1 got g=%b b=%b want 0010 1", grant, busy);
    end
    tick();
    checks++;
    if (grant !== 4'b0010 || busy !== 1'b1) begin
      errors++;
      $display("FAIL early_c2 got g=%b b=%b want 0010 1", grant, busy);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || {en3, en2, en1} !== 3'b000 ||
        owner !== 2'd1) begin
      errors++;
      $display("FAIL early_release got g=%b b=%b en=%b%b%b o=%0d want 0000 0 000 1",
               grant, busy, en3, en2, en1, owner);
    end
  endtask

  task automatic test_drop_expiry();
    reset_main(4'b1001);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0001) begin
        errors++;
        $display("FAIL drop_exp_hold cyc%0d got g=%b want 0001", i, grant);
      end
    end
    // Owner drops on the edge where the hold also expires.
    req = 4'b1000;
    tick();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_exp_gap got g=%b b=%b want 0000 0", grant, busy);
    end
    tick();
    checks++;
    if (grant !== 4'b1000 || owner !== 2'd3 || {en3, en2, en1} !== 3'b000 ||
        busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_exp_next got g=%b o=%0d en=%b%b%b b=%b want 1000 3 000 1",
               grant, owner, en3, en2, en1, busy);
    end
  endtask

  task automatic test_back_to_back_hold1();
    logic [3:0] eg;
    rst1 = 1'b1;
    req1 = 4'b0000;
    tick();
    rst1 = 1'b0;
    req1 = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      tick();
      case (i % 4)
        0:       eg = 4'b0001;
        2:       eg = 4'b0010;
        default: eg = 4'b0000;
      endcase
      checks++;
      if (grant1 !== eg || busy1 !== (eg != 0)) begin
        errors++;
        $display("FAIL hold1 cyc%0d got g=%b b=%b want g=%b", i, grant1, busy1, eg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_hold();
    test_round_robin();
    test_early_release();
    test_drop_expiry();
    test_back_to_back_hold1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
